// File: rtl/hist_pkg.sv
// Shared FSM encoding, drain length and saturating arithmetic for histogram_engine.
package hist_pkg;

  typedef enum logic [2:0] {INIT, ACCUM, DRAIN, COPY, DONE} state_e;

  localparam int unsigned DRAIN_CYCLES = 2;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] mx;
    logic [32:0] sum;
    mx  = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > mx) ? mx[31:0] : sum[31:0];
  endfunction

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned w);
    logic [32:0] mx;
    logic [32:0] sum;
    mx  = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return sum > mx;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return sat_add(v, 32'd1, w);
  endfunction

endpackage

// File: rtl/dp_bram.sv
// Simple dual-port block RAM: one write port, one synchronous read port (read-old on collision).
module dp_bram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/hist_rmw_pipe.sv
// S0/S1 read-modify-write stage with write-to-read bypass and saturation, plus
// working-RAM port muxing for the INIT clear and COPY sweep.
module hist_rmw_pipe
  import hist_pkg::*;
#(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  state_e             state_i,
  input  logic [PIXEL_W:0]   sweep_i,
  input  logic               pix_v_i,
  input  logic [PIXEL_W-1:0] pix_i,
  input  logic [COUNT_W-1:0] ram_rdata_i,
  output logic [PIXEL_W-1:0] ram_raddr_o,
  output logic               ram_we_o,
  output logic [PIXEL_W-1:0] ram_waddr_o,
  output logic [COUNT_W-1:0] ram_wdata_o,
  output logic               sat_hit_o,
  output logic               cp_v_o,
  output logic [PIXEL_W-1:0] cp_addr_o
);

  logic               s1_v_q;
  logic [PIXEL_W-1:0] s1_bin_q;
  logic               wr_v_q;
  logic [PIXEL_W-1:0] wr_bin_q;
  logic [COUNT_W-1:0] wr_data_q;
  logic               cp_v_q;
  logic [PIXEL_W-1:0] cp_addr_q;
  logic [COUNT_W-1:0] cur;
  logic [COUNT_W-1:0] inc;
  logic [31:0]        inc_full;
  logic               sweep_rd;

  // Sweep counter runs 0..BINS; its top bit marks the trailing write-only cycle.
  assign sweep_rd = (state_i == COPY) && !sweep_i[PIXEL_W];

  always_comb begin
    cur         = (wr_v_q && (wr_bin_q == s1_bin_q)) ? wr_data_q : ram_rdata_i;
    inc_full    = sat_inc(32'(cur), COUNT_W);
    inc         = inc_full[COUNT_W-1:0];
    sat_hit_o   = s1_v_q && add_ovf(32'(cur), 32'd1, COUNT_W);
    ram_raddr_o = (state_i == COPY) ? sweep_i[PIXEL_W-1:0] : pix_i;
    ram_we_o    = s1_v_q;
    ram_waddr_o = s1_bin_q;
    ram_wdata_o = inc;
    case (state_i)
      INIT: begin
        ram_we_o    = 1'b1;
        ram_waddr_o = sweep_i[PIXEL_W-1:0];
        ram_wdata_o = '0;
      end
      COPY: begin
        ram_we_o    = cp_v_q;
        ram_waddr_o = cp_addr_q;
        ram_wdata_o = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q    <= 1'b0;
      s1_bin_q  <= '0;
      wr_v_q    <= 1'b0;
      wr_bin_q  <= '0;
      wr_data_q <= '0;
      cp_v_q    <= 1'b0;
      cp_addr_q <= '0;
    end else begin
      s1_v_q    <= pix_v_i;
      s1_bin_q  <= pix_i;
      wr_v_q    <= s1_v_q;
      wr_bin_q  <= s1_bin_q;
      wr_data_q <= inc;
      cp_v_q    <= sweep_rd;
      cp_addr_q <= sweep_i[PIXEL_W-1:0];
    end
  end

  assign cp_v_o    = cp_v_q;
  assign cp_addr_o = cp_addr_q;

endmodule

// File: rtl/histogram_engine.sv
// Frame histogram with saturating bins, published to a readable output RAM on end_of_frame.
// Optional HISTOGRAM_ENGINE_CDF_EN publishes the cumulative histogram instead of raw counts.
module histogram_engine
  import hist_pkg::*;
#(
  parameter int unsigned PIXEL_W     = 8,
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_W-1:0]     in_pixel,
  input  logic                   in_valid,
  input  logic                   end_of_frame,
  output logic                   in_ready,
  input  logic [PIXEL_W-1:0]     rd_addr,
  output logic [COUNT_W-1:0]     rd_data,
  output logic                   out_valid,
  output logic                   sat,
  output logic                   eof_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned BINS = 2**PIXEL_W;
  localparam logic [PIXEL_W:0] INIT_LAST  = (PIXEL_W+1)'(BINS - 1);
  localparam logic [PIXEL_W:0] DRAIN_LAST = (PIXEL_W+1)'(DRAIN_CYCLES - 1);
  localparam logic [PIXEL_W:0] COPY_LAST  = (PIXEL_W+1)'(BINS);

  state_e                 state_q, state_d;
  logic [PIXEL_W:0]       cnt_q, cnt_d;
  logic                   sat_acc_q, sat_acc_d;
  logic                   sat_q, sat_d;
  logic                   eof_err_q, eof_err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                   accept, eof_take, copy_last;
  logic [PIXEL_W-1:0]     wk_raddr, wk_waddr, cp_addr;
  logic [COUNT_W-1:0]     wk_rdata, wk_wdata, out_wdata;
  logic                   wk_we, cp_v, sat_hit, cdf_sat;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign eof_take  = end_of_frame && in_ready;
  assign copy_last = (state_q == COPY) && (cnt_q == COPY_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      INIT:  if (cnt_q == INIT_LAST) begin state_d = ACCUM; cnt_d = '0; end
      ACCUM: begin cnt_d = '0; if (eof_take) state_d = DRAIN; end
      DRAIN: if (cnt_q == DRAIN_LAST) begin state_d = COPY; cnt_d = '0; end
      COPY:  if (copy_last) begin state_d = DONE; cnt_d = '0; end
      DONE:  begin state_d = ACCUM; cnt_d = '0; end
      default: begin state_d = INIT; cnt_d = '0; end
    endcase
  end

  // Publish-side registers update on the COPY->DONE edge so sat/frame_cnt are valid with out_valid.
  always_comb begin
    sat_acc_d   = sat_acc_q | sat_hit | cdf_sat;
    sat_d       = sat_q;
    frame_cnt_d = frame_cnt_q;
    eof_err_d   = eof_err_q | (end_of_frame & ~in_ready);
    if (copy_last) begin
      sat_d       = sat_acc_d;
      sat_acc_d   = 1'b0;
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      sat_acc_q   <= 1'b0;
      sat_q       <= 1'b0;
      eof_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sat_acc_q   <= sat_acc_d;
      sat_q       <= sat_d;
      eof_err_q   <= eof_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sat       = sat_q;
  assign eof_err   = eof_err_q;
  assign frame_cnt = frame_cnt_q;

`ifdef HISTOGRAM_ENGINE_CDF_EN
  logic [COUNT_W-1:0] cdf_q, cdf_d;
  logic [31:0]        cdf_full;

  always_comb begin
    cdf_full  = sat_add(32'(cdf_q), 32'(wk_rdata), COUNT_W);
    cdf_d     = (state_q == COPY) ? cdf_q : '0;
    if (cp_v) cdf_d = cdf_full[COUNT_W-1:0];
    cdf_sat   = cp_v && add_ovf(32'(cdf_q), 32'(wk_rdata), COUNT_W);
    out_wdata = cdf_full[COUNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cdf_q <= '0;
    else      cdf_q <= cdf_d;
  end
`else
  assign cdf_sat   = 1'b0;
  assign out_wdata = wk_rdata;
`endif

  hist_rmw_pipe #(
    .PIXEL_W(PIXEL_W),
    .COUNT_W(COUNT_W)
  ) u_pipe (
    .clk_i       (clk),
    .rst_ni      (rst),
    .state_i     (state_q),
    .sweep_i     (cnt_q),
    .pix_v_i     (accept),
    .pix_i       (in_pixel),
    .ram_rdata_i (wk_rdata),
    .ram_raddr_o (wk_raddr),
    .ram_we_o    (wk_we),
    .ram_waddr_o (wk_waddr),
    .ram_wdata_o (wk_wdata),
    .sat_hit_o   (sat_hit),
    .cp_v_o      (cp_v),
    .cp_addr_o   (cp_addr)
  );

  dp_bram #(
    .ADDR_W(PIXEL_W),
    .DATA_W(COUNT_W)
  ) u_work_ram (
    .clk_i   (clk),
    .we_i    (wk_we),
    .waddr_i (wk_waddr),
    .wdata_i (wk_wdata),
    .raddr_i (wk_raddr),
    .rdata_o (wk_rdata)
  );

  dp_bram #(
    .ADDR_W(PIXEL_W),
    .DATA_W(COUNT_W)
  ) u_out_ram (
    .clk_i   (clk),
    .we_i    (cp_v),
    .waddr_i (cp_addr),
    .wdata_i (out_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_histogram_engine.sv
// Scoreboard bench for histogram_engine: a 16-bit-count instance and a 4-bit-count instance.
module tb_histogram_engine;

  localparam int unsigned BINS = 256;

  typedef struct { int unsigned addr; int unsigned val; } bin_t;
  typedef struct { int unsigned fc;   logic s;          } frm_t;

  logic       clk;
  logic [1:0] rst_n, vld, eof;
  logic [7:0] pix   [2];
  logic [7:0] raddr [2];

  logic        rdy8, ov8, sat8, eerr8, rdy4, ov4, sat4, eerr4;
  logic [15:0] rdata8, fcnt8, fcnt4;
  logic [3:0]  rdata4;

  bin_t        bin_q [$];
  frm_t        frm_q [$];
  int unsigned stim  [$];
  int unsigned fc_model [2] = '{0, 0};
  int unsigned ov_seen  [2] = '{0, 0};
  int unsigned n_chk = 0, n_pass = 0, base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  histogram_engine #(.PIXEL_W(8), .COUNT_W(16), .FRAME_CNT_W(16)) dut8 (
    .clk(clk), .rst(rst_n[0]), .in_pixel(pix[0]), .in_valid(vld[0]), .end_of_frame(eof[0]),
    .in_ready(rdy8), .rd_addr(raddr[0]), .rd_data(rdata8), .out_valid(ov8), .sat(sat8),
    .eof_err(eerr8), .frame_cnt(fcnt8));

  histogram_engine #(.PIXEL_W(8), .COUNT_W(4), .FRAME_CNT_W(16)) dut4 (
    .clk(clk), .rst(rst_n[1]), .in_pixel(pix[1]), .in_valid(vld[1]), .end_of_frame(eof[1]),
    .in_ready(rdy4), .rd_addr(raddr[1]), .rd_data(rdata4), .out_valid(ov4), .sat(sat4),
    .eof_err(eerr4), .frame_cnt(fcnt4));

  always @(negedge clk) begin
    if (ov8) ov_seen[0]++;
    if (ov4) ov_seen[1]++;
  end

  function automatic logic get_rdy(input int s);  return (s != 0) ? rdy4 : rdy8; endfunction
  function automatic logic get_ov(input int s);   return (s != 0) ? ov4 : ov8;   endfunction
  function automatic logic get_sat(input int s);  return (s != 0) ? sat4 : sat8; endfunction
  function automatic logic [15:0] get_fcnt(input int s);  return (s != 0) ? fcnt4 : fcnt8; endfunction
  function automatic logic [15:0] get_rdata(input int s); return (s != 0) ? 16'(rdata4) : rdata8; endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_frame(input int s);
    int unsigned h [BINS];
    int unsigned mx, run;
    logic sf;
    bin_t b;
    frm_t f;
    mx  = (s != 0) ? 15 : 65535;
    sf  = 1'b0;
    run = 0;
    for (int k = 0; k < BINS; k++) h[k] = 0;
    foreach (stim[i]) begin
      if (h[stim[i]] == mx) sf = 1'b1;
      else h[stim[i]]++;
    end
    for (int k = 0; k < BINS; k++) begin
      b.addr = k;
`ifdef HISTOGRAM_ENGINE_CDF_EN
      run += h[k];
      if (run > mx) begin run = mx; sf = 1'b1; end
      b.val = run;
`else
      b.val = h[k];
`endif
      bin_q.push_back(b);
    end
    fc_model[s] = (fc_model[s] + 1) % 65536;
    f.fc = fc_model[s];
    f.s  = sf;
    frm_q.push_back(f);
  endtask

  task automatic wait_ready(input int s);
    int unsigned n = 0;
    while (!get_rdy(s) && n < 1000) begin @(negedge clk); n++; end
    chk("ready_before_frame", get_rdy(s), 1);
  endtask

  task automatic send_frame(input int s, input bit do_model);
    wait_ready(s);
    if (do_model) model_frame(s);
    if (stim.size() == 0) begin
      eof[s] = 1'b1;
      @(negedge clk);
    end else begin
      for (int i = 0; i < stim.size(); i++) begin
        pix[s] = 8'(stim[i]);
        vld[s] = 1'b1;
        eof[s] = (i == stim.size() - 1);
        @(negedge clk);
      end
    end
    vld[s] = 1'b0;
    eof[s] = 1'b0;
    chk("rdy_drop", get_rdy(s), 0);
  endtask

  // Waits for out_valid counting cycles from eof acceptance; optionally pokes eof mid-flight.
  task automatic publish(input int s, input int unsigned poke);
    int unsigned lat;
    frm_t f;
    bin_t b;
    lat = 1;
    while (!get_ov(s) && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (poke != 0) eof[s] = (lat == poke);
    end
    eof[s] = 1'b0;
    chk("latency", lat, BINS + 4);
    chk("frm_q_depth", frm_q.size(), 1);
    if (frm_q.size() > 0) begin
      f = frm_q.pop_front();
      chk("frame_cnt", get_fcnt(s), f.fc);
      chk("sat", get_sat(s), f.s);
    end
    while (bin_q.size() > 0) begin
      b = bin_q.pop_front();
      raddr[s] = 8'(b.addr);
      @(negedge clk);
      chk($sformatf("bin%0d_%0d", s, b.addr), get_rdata(s), b.val);
    end
  endtask

  task automatic check_init(input int s);
    bit early = 1'b0;
    int unsigned ovc = 0;
    for (int n = 1; n <= 256; n++) begin
      @(negedge clk);
      if (get_ov(s)) ovc++;
      if (n < 256 && get_rdy(s)) early = 1'b1;
      if (n == 256) chk("init_rdy_rise", get_rdy(s), 1);
    end
    chk("init_rdy_early", early, 0);
    chk("init_ov", ovc, 0);
  endtask

  initial begin
    rst_n = '0; vld = '0; eof = '0;
    for (int s = 0; s < 2; s++) begin pix[s] = '0; raddr[s] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy8, 0);
    chk("rst_ov", ov8, 0);
    chk("rst_sat", sat8, 0);
    chk("rst_eerr", eerr8, 0);
    chk("rst_fcnt", fcnt8, 0);
    rst_n = 2'b11;
    check_init(0);
    chk("init4_rdy", rdy4, 1);

    stim.delete();
    repeat (10) stim.push_back(5);
    send_frame(0, 1); publish(0, 0);

    stim.delete();
    send_frame(0, 1); publish(0, 0);

    stim = '{3, 3, 7, 3, 7, 7, 7};
    send_frame(0, 1); publish(0, 0);

    stim.delete();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       stim.push_back(0);
        1:       stim.push_back(1);
        2:       stim.push_back(2);
        default: stim.push_back(255);
      endcase
    end
    send_frame(0, 1); publish(0, 0);

    stim = '{0, 1, 1, 2};
    send_frame(0, 1); publish(0, 0);

    stim.delete();
    repeat (20) stim.push_back(9);
    send_frame(1, 1); publish(1, 0);
    stim = '{9};
    send_frame(1, 1); publish(1, 0);

    chk("eerr_clean", eerr8, 0);
    base = ov_seen[0];
    stim = '{1, 2, 2};
    send_frame(0, 1); publish(0, 100);
    chk("eof_err_sticky", eerr8, 1);
    repeat (300) @(negedge clk);
    chk("eof_copy_single_ov", ov_seen[0] - base, 1);
    chk("rdy_after_copy_eof", rdy8, 1);

    stim = '{4, 4};
    send_frame(0, 0);
    repeat (120) @(negedge clk);
    base = ov_seen[0];
    rst_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_rdy", rdy8, 0);
    chk("rst_mid_eerr", eerr8, 0);
    chk("rst_mid_fcnt", fcnt8, 0);
    rst_n[0] = 1'b1;
    fc_model[0] = 0;
    check_init(0);
    chk("rst_mid_no_ov", ov_seen[0] - base, 0);
    stim.delete();
    send_frame(0, 1); publish(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
